// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV64M multiply/divide unit with valid/ready handshakes.
// Define ALU_MULDIV_FAST_MUL_EN to compute multiplies in a single CALC cycle.
module alu_muldiv #(
  parameter int DATA_WIDTH    = 64,
  parameter int WORD_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [CONTROL_WIDTH-1:0] i_op,
  input  logic [DATA_WIDTH-1:0]    i_src_1,
  input  logic [DATA_WIDTH-1:0]    i_src_2,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH-1:0]    o_result
);

  localparam int DW = DATA_WIDTH;
  localparam int WW = WORD_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]            count;
  logic [CONTROL_WIDTH-1:0] op_reg;
  logic [DW-1:0]            a, b, hi, lo;
  logic                     neg_a, neg_b;

  function automatic logic [DW-1:0] ext(
    input logic [DW-1:0] v,
    input logic          w,
    input logic          s
  );
    if (!w) return v;
    return {{(DW-WW){s & v[WW-1]}}, v[WW-1:0]};
  endfunction

  function automatic logic [DW-1:0] sext_w(
    input logic [DW-1:0] v,
    input logic          w
  );
    if (!w) return v;
    return {{(DW-WW){v[WW-1]}}, v[WW-1:0]};
  endfunction

  logic          word, is_div, legal, special;
  logic          sign1, sign2, neg1, neg2, div_zero, ovf;
  logic [1:0]    sub;
  logic [DW-1:0] val1, val2, mag1, mag2, min_val, spec_res;

  always_comb begin
    word   = i_op[3];
    is_div = i_op[2];
    sub    = i_op[1:0];
    legal  = is_div || !word || (sub == 2'b00);
    if (is_div) begin
      sign1 = !sub[0];
      sign2 = !sub[0];
    end else begin
      sign1 = word || (sub == 2'b01) || (sub == 2'b10);
      sign2 = word || (sub == 2'b01);
    end
    val1 = ext(i_src_1, word, sign1);
    val2 = ext(i_src_2, word, sign2);
    neg1 = sign1 & val1[DW-1];
    neg2 = sign2 & val2[DW-1];
    mag1 = neg1 ? -val1 : val1;
    mag2 = neg2 ? -val2 : val2;
    min_val = word ? {{(DW-WW+1){1'b1}}, {(WW-1){1'b0}}}
                   : {1'b1, {(DW-1){1'b0}}};
    div_zero = is_div && (val2 == '0);
    ovf      = is_div && sign1 && (val1 == min_val) && (val2 == '1);
    special  = !legal || div_zero || ovf;
    spec_res = '0;
    if (!legal)
      spec_res = '0;
    else if (div_zero)
      spec_res = sub[1] ? val1 : '1;
    else if (ovf)
      spec_res = sub[1] ? '0 : val1;
    spec_res = sext_w(spec_res, word);
  end

  // Restoring divide: hi < b holds, so the 65-bit difference sign is exact.
  logic [DW:0] shifted, diff;
  logic        nonneg;

  always_comb begin
    shifted = {hi, lo[DW-1]};
    diff    = shifted - {1'b0, b};
    nonneg  = !diff[DW];
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*DW-1:0] fast_prod;

  always_comb begin
    fast_prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  end
`else
  logic [DW:0] sum;

  always_comb begin
    sum = lo[0] ? ({1'b0, hi} + {1'b0, a}) : {1'b0, hi};
  end
`endif

  logic [2*DW-1:0] prod, prod_sel, prod_fix;
  logic [DW-1:0]   quo, rem, raw, fix_res;

  always_comb begin
    prod = {hi, lo};
`ifdef ALU_MULDIV_FAST_MUL_EN
    prod_sel = prod;
`else
    // W multiplies run half the iterations, leaving the product WW bits up.
    prod_sel = op_reg[3] ? (prod >> WW) : prod;
`endif
    prod_fix = (neg_a ^ neg_b) ? -prod_sel : prod_sel;
    quo      = (neg_a ^ neg_b) ? -lo : lo;
    rem      = neg_a ? -hi : hi;
    raw      = '0;
    unique case (1'b1)
      op_reg[2]:
        raw = op_reg[1] ? rem : quo;
      (!op_reg[2] && op_reg[1:0] == 2'b00):
        raw = prod_fix[DW-1:0];
      (!op_reg[2] && op_reg[1:0] != 2'b00):
        raw = prod_fix[2*DW-1:DW];
      default:
        raw = '0;
    endcase
    fix_res = sext_w(raw, op_reg[3]);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (i_valid) state_next = special ? DONE : CALC;
      CALC: if (count == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (i_flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count    <= '0;
      op_reg   <= '0;
      a        <= '0;
      b        <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      o_result <= '0;
    end else if (!i_flush) begin
      unique case (state)
        IDLE: if (i_valid) begin
          op_reg <= i_op;
          a      <= mag1;
          b      <= mag2;
          neg_a  <= neg1;
          neg_b  <= neg2;
          hi     <= '0;
          if (!is_div)
            lo <= mag2;
          else if (word)
            lo <= {mag1[WW-1:0], {(DW-WW){1'b0}}};
          else
            lo <= mag1;
`ifdef ALU_MULDIV_FAST_MUL_EN
          if (!is_div)   count <= CW'(1);
          else if (word) count <= CW'(WW);
          else           count <= CW'(DW);
`else
          count <= word ? CW'(WW) : CW'(DW);
`endif
          if (special) o_result <= spec_res;
        end
        CALC: begin
          count <= count - CW'(1);
          if (op_reg[2]) begin
            hi <= nonneg ? diff[DW-1:0] : shifted[DW-1:0];
            lo <= {lo[DW-2:0], nonneg};
          end else begin
`ifdef ALU_MULDIV_FAST_MUL_EN
            {hi, lo} <= fast_prod;
`else
            hi <= sum[DW:1];
            lo <= {sum[0], lo[DW-1:1]};
`endif
          end
        end
        FIX: o_result <= fix_res;
        default: ;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors, handshake corner cases and
// randomized checks of alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        arst, i_flush, i_valid, i_ready;
  logic        o_ready, o_valid;
  logic [3:0]  i_op;
  logic [63:0] i_src_1, i_src_2, o_result;

  int tests = 0;
  int fails = 0;

`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int ML = 3, MWL = 3;
`else
  localparam int ML = 66, MWL = 34;
`endif
  localparam int DL = 66, DWL = 34;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  alu_muldiv dut (
    .clk      (clk),
    .arst     (arst),
    .i_flush  (i_flush),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_src_1  (i_src_1),
    .i_src_2  (i_src_2),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model(input logic [3:0] op,
                                        input logic [63:0] x,
                                        input logic [63:0] y);
    logic [127:0]       p;
    logic signed [63:0] sx, sy;
    logic signed [31:0] wx, wy;
    logic [31:0]        ux, uy, w;
    sx = x; sy = y;
    wx = x[31:0]; wy = y[31:0];
    ux = x[31:0]; uy = y[31:0];
    case (op)
      4'd0: return x * y;
      4'd1: begin
        p = {{64{x[63]}}, x} * {{64{y[63]}}, y};
        return p[127:64];
      end
      4'd2: begin
        p = {{64{x[63]}}, x} * {64'd0, y};
        return p[127:64];
      end
      4'd3: begin
        p = {64'd0, x} * {64'd0, y};
        return p[127:64];
      end
      4'd4: begin
        if (y == 0) return ONES;
        if (x == MIN64 && y == ONES) return x;
        return sx / sy;
      end
      4'd5: return (y == 0) ? ONES : x / y;
      4'd6: begin
        if (y == 0) return x;
        if (x == MIN64 && y == ONES) return 64'd0;
        return sx % sy;
      end
      4'd7: return (y == 0) ? x : x % y;
      4'd8: begin
        w = ux * uy;
        return sx32(w);
      end
      4'd12: begin
        if (wy == 0) return ONES;
        if (ux == 32'h8000_0000 && uy == 32'hFFFF_FFFF) return sx32(ux);
        w = wx / wy;
        return sx32(w);
      end
      4'd13: begin
        if (uy == 0) return ONES;
        w = ux / uy;
        return sx32(w);
      end
      4'd14: begin
        if (wy == 0) return sx32(ux);
        if (ux == 32'h8000_0000 && uy == 32'hFFFF_FFFF) return 64'd0;
        w = wx % wy;
        return sx32(w);
      end
      4'd15: begin
        if (uy == 0) return sx32(ux);
        w = ux % uy;
        return sx32(w);
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op,
                                 input logic [63:0] x,
                                 input logic [63:0] y);
    bit zero, ovf;
    if (op == 4'd9 || op == 4'd10 || op == 4'd11) return 1;
    if (op[2]) begin
      zero = op[3] ? (y[31:0] == 0) : (y == 0);
      ovf  = !op[0] && (op[3]
             ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
             : (x == MIN64 && y == ONES));
      if (zero || ovf) return 1;
      return op[3] ? DWL : DL;
    end
    return op[3] ? MWL : ML;
  endfunction

  // Latency counts edges from the acceptance edge (inclusive) to o_valid.
  task automatic run_op(input logic [3:0] op, input logic [63:0] s1,
                        input logic [63:0] s2, output logic [63:0] res,
                        output int lat);
    i_op = op; i_src_1 = s1; i_src_2 = s2; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 120) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o_result;
    if (o_valid) begin
      @(posedge clk); #1;
    end else begin
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
    end
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return {32'($urandom), 32'h8000_0000};
      5: return -64'($urandom_range(1, 20));
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  vec_t        v [17];
  logic [3:0]  ops [14];
  logic [63:0] res, s1, s2;
  logic [3:0]  op;
  int          lat, n;
  bit          saw;

  initial begin
    v[0]  = '{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
              64'hFFFF_FFFF_FFFF_FFEB, ML};
    v[1]  = '{4'd3,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, ML};
    v[2]  = '{4'd1,  ONES, ONES, 64'd0, ML};
    v[3]  = '{4'd4,  -64'd20, 64'd3, -64'd6, DL};
    v[4]  = '{4'd6,  -64'd20, 64'd3, -64'd2, DL};
    v[5]  = '{4'd5,  64'd100, 64'd0, ONES, 1};
    v[6]  = '{4'd7,  64'd100, 64'd0, 64'd100, 1};
    v[7]  = '{4'd4,  MIN64, ONES, MIN64, 1};
    v[8]  = '{4'd12, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1};
    v[9]  = '{4'd8,  64'd3, 64'd5, 64'd15, MWL};
    v[10] = '{4'd9,  64'd3, 64'd5, 64'd0, 1};
    v[11] = '{4'd14, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
    v[12] = '{4'd2,  ONES, 64'd2, ONES, ML};
    v[13] = '{4'd13, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, DWL};
    v[14] = '{4'd14, -64'd7, 64'd2, ONES, DWL};
    v[15] = '{4'd8,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MWL};
    v[16] = '{4'd15, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1};
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
            4'd7, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15, 4'd9};

    arst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_op = '0; i_src_1 = '0; i_src_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(o_ready), 64'd1);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_result", o_result, 64'd0);
    arst = 1'b0;
    @(posedge clk); #1;

    foreach (v[i]) begin
      run_op(v[i].op, v[i].s1, v[i].s2, res, lat);
      check($sformatf("vec%0d_result", i), res, v[i].res);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(v[i].lat));
    end

    // Backpressure: result must be held while the consumer stalls.
    i_ready = 1'b0;
    i_op = 4'd4; i_src_1 = 64'd1000; i_src_2 = 64'd7; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 120) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid", 64'(o_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(o_valid), 64'd1);
      check("bp_hold_result", o_result, 64'd142);
      check("bp_hold_ready", 64'(o_ready), 64'd0);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(o_valid), 64'd0);
    check("bp_release_ready", 64'(o_ready), 64'd1);

    // Flush at cycle 20 of a divide.
    i_op = 4'd4; i_src_1 = 64'd12345; i_src_2 = 64'd11; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 19; k++) begin
      @(posedge clk); #1;
      if (o_valid) saw = 1'b1;
    end
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_ready", 64'(o_ready), 64'd1);
    check("flush_valid", 64'(o_valid), 64'd0);
    check("flush_no_early_valid", 64'(saw), 64'd0);
    check("flush_result_kept", o_result, 64'd142);
    run_op(4'd5, 64'd50, 64'd5, res, lat);
    check("post_flush_result", res, 64'd10);
    check("post_flush_latency", 64'(lat), 64'(DL));

    // Asynchronous reset in the middle of a W multiply.
    i_op = 4'd8; i_src_1 = 64'h1234; i_src_2 = 64'h10; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (29) @(posedge clk);
    #3;
    arst = 1'b1;
    #1;
    check("arst_ready", 64'(o_ready), 64'd1);
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_result", o_result, 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
    run_op(4'd8, 64'd3, 64'd5, res, lat);
    check("post_arst_mulw", res, 64'd15);
    check("post_arst_latency", 64'(lat), 64'(MWL));

    for (int r = 0; r < 150; r++) begin
      op = ops[$urandom_range(0, 13)];
      s1 = rnd_val();
      s2 = rnd_val();
      run_op(op, s1, s2, res, lat);
      check($sformatf("rand%0d_op%0d_%h_%h", r, op, s1, s2),
            res, model(op, s1, s2));
      check($sformatf("rand%0d_op%0d_latency", r, op),
            64'(lat), 64'(exp_lat(op, s1, s2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative RV64M multiply/divide unit that sits beside the single-cycle integer ALU in the execute stage and handles every M-extension operation, including the word (W) forms. Operands are accepted through a valid/ready handshake. The result is computed over a bounded number of cycles and held on a valid/ready output until the pipeline consumes it. A flush input kills an in-flight operation for trap and branch recovery.

## Interface
Parameters:
- DATA_WIDTH, 64: full operand and result width.
- WORD_WIDTH, 32: width of W-form operations.
- CONTROL_WIDTH, 4: width of the operation select.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous kill of the in-flight or held operation.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request.
- i_op  in  CONTROL_WIDTH  operation select.
- i_src_1  in  DATA_WIDTH  rs1 (multiplicand / dividend).
- i_src_2  in  DATA_WIDTH  rs2 (multiplier / divisor).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  DATA_WIDTH  result.

## Operation
- Opcodes:
  - MUL 0000, MULH 0001, MULHSU 0010, MULHU 0011.
  - DIV 0100, DIVU 0101, REM 0110, REMU 0111.
  - MULW 1000.
  - DIVW 1100, DIVUW 1101, REMW 1110, REMUW 1111.
  - 1001–1011 are illegal.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid, latch the opcode and the operand magnitudes with their signs.
  - W forms use src[31:0]: sign-extended for signed ops, zero-extended for unsigned ops.
  - Load the iteration counter N: DATA_WIDTH for 64-bit ops, WORD_WIDTH for W forms.
  - Go to CALC.
- Special cases bypass CALC and go IDLE→DONE:
  - Divisor zero: quotient = all ones; remainder = dividend (after W extension).
  - Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.
  - Illegal opcode: result 0.
- CALC, one iteration per cycle, counter decremented; when the counter reaches 0, go to FIX.
  - Multiply: radix-2 shift-add into a 2×DATA_WIDTH product register.
  - Divide: restoring divide; shift the remainder left, subtract the divisor, set the quotient bit if non-negative.
- FIX:
  - Negate the product when the operand signs differ (MULH: both operands signed; MULHSU: src_1 only).
  - Quotient sign is sign(dividend) XOR sign(divisor); remainder takes the dividend's sign.
  - Select the low half (MUL, MULW) or the high half (MULH*) of the product.
  - W results are sign-extended from bit 31.
  - Register o_result; go to DONE.
- DONE: o_valid=1, o_result stable; on i_ready go to IDLE.
- i_flush in any state: next state IDLE; o_valid=0; o_result unchanged. i_flush has priority over i_valid and i_ready in the same cycle.
- Arithmetic is modulo 2^DATA_WIDTH; no flags are produced.

## Timing
- Reset values: o_ready=1, o_valid=0, o_result=0, state IDLE, counter 0.
- Reset is asserted asynchronously at any point, including mid-CALC; the operation is lost.
- Normal latency: with acceptance edge at cycle 0, o_valid rises at cycle N+2 (66 for 64-bit ops, 34 for W forms).
- Special-case latency: o_valid at cycle 1.
- o_ready=0 in CALC, FIX and DONE; a new request is accepted no earlier than the cycle after the result handshake (no back-to-back overlap).
- o_valid is held for as long as i_ready=0; o_result must not change while o_valid=1.

## Configuration
- ALU_MULDIV_FAST_MUL_EN defined:
  - MUL, MULH, MULHSU, MULHU and MULW use a combinational DATA_WIDTH×DATA_WIDTH product in a single CALC cycle.
  - Multiply latency is 3 (IDLE→CALC→FIX→DONE).
  - Divides are unchanged.
- Not defined: all multiplies are iterative as described under Operation.

## Test plan
- MUL, src_1=7, src_2=0xFFFF_FFFF_FFFF_FFFD → o_result=0xFFFF_FFFF_FFFF_FFEB; o_valid at cycle 66 (cycle 3 with ALU_MULDIV_FAST_MUL_EN).
- MULHU, both operands 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULH on the same operands → 0.
- DIV, src_1=−20, src_2=3 → −6; REM on the same operands → −2; DIVU 100/0 → all ones at cycle 1; REMU 100/0 → 100.
- DIV, src_1=0x8000_0000_0000_0000, src_2=−1 → 0x8000_0000_0000_0000 at cycle 1. DIVW, src_1=0x0000_0000_8000_0000, src_2=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- Backpressure and flush:
  - Hold i_ready=0 for 10 cycles in DONE → o_valid and o_result stable, o_ready=0.
  - i_flush at cycle 20 of a DIV → IDLE next cycle, o_valid never asserted, new request accepted.
- Assert arst at cycle 30 of a MULW → outputs take reset values immediately; a fresh MULW 3×5 after release returns 15.
